io_vector_sampler: RTL and testbench



---
 rtl/io_vec_pkg.sv | 10 +
 rtl/io_vector_sampler_sync_fifo.sv | 56 +++++
 rtl/io_vector_sampler.sv | 77 +++++++
 tb/tb_io_vector_sampler.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/io_vec_pkg.sv
// Shared defaults and the FIFO entry layout for the pin-vector sampler.
package io_vec_pkg;
   localparam int WIDTH_D   = 5;
   localparam int STAMP_W_D = 16;

   typedef struct packed {
      logic [STAMP_W_D-1:0] stamp;
      logic [WIDTH_D-1:0]   vector;
   } entry_t;
endpackage

// File: rtl/io_vector_sampler_sync_fifo.sv
// Circular-buffer FIFO with a registered head output that is valid in the
// same cycle rd_valid rises (write data is forwarded into the head register).
module sync_fifo #(
   parameter int W     = 21,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             wr_data,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [W-1:0]             rd_data
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
   logic [CW-1:0] count_n;
   logic          do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   // A push into a full FIFO only lands when the head leaves in the same cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   always_comb begin
      rd_ptr_n = rd_ptr;
      if (do_pop) rd_ptr_n = rd_ptr + 1'b1;
      count_n = count + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_ptr_n;
         count  <= count_n;
         // Empty: hold last head value; consumers qualify with rd_valid.
         if (count_n != '0)
            rd_data <= (do_push && (wr_ptr == rd_ptr_n)) ? wr_data : mem[rd_ptr_n];
      end
   end
endmodule

// File: rtl/io_vector_sampler.sv
// Synchronises pad inputs, accepts a vector once stable for STABLE_CYCLES,
// and queues {stamp, vector} entries for a downstream consumer.
module io_vector_sampler
   import io_vec_pkg::*;
#(
   parameter int WIDTH         = WIDTH_D,
   parameter int STABLE_CYCLES = 3,
   parameter int DEPTH         = 8,
   parameter int STAMP_W       = STAMP_W_D
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           pin_in,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [STAMP_W+WIDTH-1:0]   rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       ovf,
   input  logic                       clr_ovf
);
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0]   meta, s, cand, committed;
   logic [CNT_W-1:0]   cnt;
   logic [STAMP_W-1:0] stamp;
   logic               commit, full, empty, pop;

   assign commit   = (s == cand) && (cnt == CNT_MAX) && (cand != committed);
   assign pop      = rd_valid && rd_ready;
   assign rd_valid = !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta      <= '0;
         s         <= '0;
         cand      <= '0;
         cnt       <= '0;
         committed <= '0;
         stamp     <= '0;
      end else begin
         meta  <= pin_in;
         s     <= meta;
         stamp <= stamp + 1'b1;
         if (s != cand) begin
            cand <= s;
            cnt  <= '0;
         end else if (cnt < CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end else if (cand != committed) begin
            // Updated even when the entry is dropped so the drop is not retried.
            committed <= cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       ovf <= 1'b0;
      else if (commit && full && !pop)  ovf <= 1'b1;
      else if (clr_ovf)                 ovf <= 1'b0;
   end

   sync_fifo #(
      .W     (STAMP_W + WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (commit),
      .wr_data ({stamp, cand}),
      .pop     (pop),
      .full    (full),
      .empty   (empty),
      .count   (count),
      .rd_data (rd_data)
   );
endmodule

// File: tb/tb_io_vector_sampler.sv
// Scoreboard bench: stimulus queues expected entries, a negedge monitor
// checks every handshaken head entry.
module tb_io_vector_sampler;
   import io_vec_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  pin_in = '0;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic [20:0] rd_data;
   logic [3:0]  count;
   logic        ovf;
   logic        clr_ovf = 1'b0;

   entry_t exp_q[$];
   int     compared = 0;
   int     mismatched = 0;
   int     edges = 0;

   io_vector_sampler dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pin_in   (pin_in),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .rd_data  (rd_data),
      .count    (count),
      .ovf      (ovf),
      .clr_ovf  (clr_ovf)
   );

   always #5 clk = ~clk;

   // Clock edges since reset release; equals the DUT stamp before each edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edges <= 0;
      else        edges <= edges + 1;
   end

   always @(negedge clk) begin
      if (rst_n && rd_valid && rd_ready) begin
         entry_t got, exp;
         got = entry_t'(rd_data);
         compared++;
         if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL entry: unexpected stamp=%0d vec=%b, none required", got.stamp, got.vector);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               mismatched++;
               $display("FAIL entry: got stamp=%0d vec=%b, required stamp=%0d vec=%b",
                        got.stamp, got.vector, exp.stamp, exp.vector);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Pin change issued just after edge k is captured at k+1 and pushed at
   // edge k+6, whose pre-increment stamp is k+5.
   task automatic drive(input logic [4:0] v, input bit expect_push, input int hold);
      entry_t e;
      pin_in = v;
      if (expect_push) begin
         e.stamp  = 16'(edges + 5);
         e.vector = v;
         exp_q.push_back(e);
      end
      tick(hold);
   endtask

   initial begin
      #12;
      check("reset rd_valid", int'(rd_valid), 0);
      check("reset count", int'(count), 0);
      check("reset ovf", int'(ovf), 0);
      check("reset rd_data", int'(rd_data), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Idle zeros: nothing queued.
      tick(50);
      check("idle rd_valid", int'(rd_valid), 0);
      check("idle count", int'(count), 0);

      rd_ready = 1'b1;
      drive(5'b10011, 1'b1, 12);
      check("single count", int'(count), 0);

      // Back to zero, then a 2-cycle glitch, then a real hold.
      drive(5'b00000, 1'b1, 10);
      drive(5'b00100, 1'b0, 2);
      drive(5'b00000, 1'b0, 10);
      check("glitch count", int'(count), 0);
      drive(5'b00100, 1'b1, 10);

      // Fill with rd_ready low: 8 land, last 2 dropped.
      rd_ready = 1'b0;
      for (int i = 0; i < 10; i++) drive(5'(11 + i), (i < 8), 6);
      tick(2);
      check("fill count", int'(count), 8);
      check("fill ovf", int'(ovf), 1);

      clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
      check("clr ovf", int'(ovf), 0);

      // Full FIFO: pop coincides with push edge.
      drive(5'h1f, 1'b1, 5);
      rd_ready = 1'b1; tick(1); rd_ready = 1'b0;
      check("full push+pop count", int'(count), 8);
      check("full push+pop ovf", int'(ovf), 0);

      // Dropping push coincides with clr_ovf: set wins.
      drive(5'h00, 1'b0, 5);
      clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
      check("set over clr ovf", int'(ovf), 1);
      check("drop count", int'(count), 8);
      tick(3);

      rd_ready = 1'b1; tick(12); rd_ready = 1'b0;
      check("drain count", int'(count), 0);
      check("drain queue", exp_q.size(), 0);

      // Asynchronous reset with entries queued.
      drive(5'h03, 1'b0, 6);
      drive(5'h05, 1'b0, 6);
      drive(5'h07, 1'b0, 6);
      check("pre-reset count", int'(count), 3);
      pin_in = 5'b00001;
      #3 rst_n = 1'b0;
      #1;
      check("async rd_valid", int'(rd_valid), 0);
      check("async count", int'(count), 0);
      check("async ovf", int'(ovf), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      rd_ready = 1'b1;
      drive(5'b00001, 1'b1, 10);
      check("post-reset count", int'(count), 0);

      // Long run across the stamp wrap.
      for (int i = 0; i < 10000; i++)
         drive(i[0] ? 5'h15 : 5'h0a, 1'b1, 7);
      tick(10);
      check("wrap edges reached", int'(edges > 65536), 1);
      check("final queue", exp_q.size(), 0);
      check("final count", int'(count), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
